// File: rtl/tx0_frame_scheduler.sv
// Shares the tx0 frame generator between paced test traffic and ARP requests (ARP first).
// Optional frame/ARP start counters are built when TX0_SCHED_STATS_EN is defined.
module tx0_frame_scheduler #(
    parameter logic [15:0] MIN_LEN = 16'd60,
    parameter logic [15:0] MAX_LEN = 16'd1518,
    parameter logic [15:0] ARP_LEN = 16'd60,
    parameter logic [19:0] TIMEOUT = 20'hFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_enable,
    input  logic        arp_req,
    input  logic [15:0] frame_len,
    input  logic [31:0] inter_frame_gap,
    output logic        gen_start,
    output logic        gen_sel,
    output logic [15:0] gen_len,
    input  logic        gen_done,
    output logic        arp_pending,
    output logic        busy,
    output logic        timeout_err
`ifdef TX0_SCHED_STATS_EN
    ,
    output logic [31:0] frame_cnt,
    output logic [31:0] arp_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        arp_req_q;
    logic        arp_pending_q, arp_pending_d;
    logic        gen_start_q, gen_start_d;
    logic        gen_sel_q, gen_sel_d;
    logic [15:0] gen_len_q, gen_len_d;
    logic        busy_q, busy_d;
    logic        timeout_err_q, timeout_err_d;
    logic [19:0] wd_cnt_q, wd_cnt_d;
    logic [31:0] gap_cnt_q, gap_cnt_d;
    logic [15:0] clamped_len;
    logic        arp_edge;

    assign arp_edge = arp_req & ~arp_req_q;

    always_comb begin
        clamped_len = frame_len;
        if (frame_len < MIN_LEN)
            clamped_len = MIN_LEN;
        else if (frame_len > MAX_LEN)
            clamped_len = MAX_LEN;
    end

    always_comb begin
        state_d       = state_q;
        arp_pending_d = arp_pending_q;
        gen_sel_d     = gen_sel_q;
        gen_len_d     = gen_len_q;
        timeout_err_d = timeout_err_q;
        wd_cnt_d      = wd_cnt_q;
        gap_cnt_d     = gap_cnt_q;

        case (state_q)
            IDLE: begin
                if (arp_pending_q || tx_enable) begin
                    state_d   = START;
                    gen_sel_d = arp_pending_q;
                    gen_len_d = arp_pending_q ? ARP_LEN : clamped_len;
                    if (arp_pending_q)
                        arp_pending_d = 1'b0;
                end
            end
            START: begin
                wd_cnt_d = '0;
                state_d  = BUSY;
            end
            BUSY: begin
                // A completion coinciding with watchdog expiry is a normal completion.
                if (gen_done) begin
                    gap_cnt_d = inter_frame_gap;
                    state_d   = (inter_frame_gap == 32'd0) ? IDLE : GAP;
                end else if (wd_cnt_q == TIMEOUT) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    wd_cnt_d = wd_cnt_q + 20'd1;
                end
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q - 32'd1;
                if (gap_cnt_q == 32'd1)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A new request edge beats the clear issued on the same cycle.
        if (arp_edge)
            arp_pending_d = 1'b1;

        gen_start_d = (state_d == START);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            arp_req_q     <= 1'b0;
            arp_pending_q <= 1'b0;
            gen_start_q   <= 1'b0;
            gen_sel_q     <= 1'b0;
            gen_len_q     <= 16'd0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            wd_cnt_q      <= 20'd0;
            gap_cnt_q     <= 32'd0;
        end else begin
            state_q       <= state_d;
            arp_req_q     <= arp_req;
            arp_pending_q <= arp_pending_d;
            gen_start_q   <= gen_start_d;
            gen_sel_q     <= gen_sel_d;
            gen_len_q     <= gen_len_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            wd_cnt_q      <= wd_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
        end
    end

    assign gen_start   = gen_start_q;
    assign gen_sel     = gen_sel_q;
    assign gen_len     = gen_len_q;
    assign arp_pending = arp_pending_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

`ifdef TX0_SCHED_STATS_EN
    logic [31:0] frame_cnt_q, frame_cnt_d;
    logic [31:0] arp_cnt_q, arp_cnt_d;

    // Counted on the same edge that raises gen_start, so they move together.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        arp_cnt_d   = arp_cnt_q;
        if (state_d == START) begin
            if (gen_sel_d)
                arp_cnt_d = arp_cnt_q + 32'd1;
            else
                frame_cnt_d = frame_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= 32'd0;
            arp_cnt_q   <= 32'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            arp_cnt_q   <= arp_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign arp_cnt   = arp_cnt_q;
`endif

endmodule
